// File: rtl/vedic_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : vedic_sum_accumulator
// Description : Accumulates BLOCK_LEN {cout, sum} results from the 32-bit
//               vedic adder into an ACC_W-bit total. The total is offered on
//               a valid/ready output handshake.
//               Optional macro SATURATE_EN: when it is defined, an overflow
//               clamps the total to all-ones. When it is undefined, the total
//               wraps modulo 2^ACC_W.
// Ports       : clk       - rising-edge clock
//               rst_n     - synchronous active-low reset
//               sum_in    - 32-bit adder sum
//               cout_in   - adder carry-out
//               in_valid  - sample present
//               in_ready  - block accepts a sample this cycle
//               flush     - synchronous abort of the current block
//               acc_out   - block total
//               out_valid - acc_out holds a completed block
//               out_ready - consumer takes acc_out
//               ovf       - sticky overflow for current/last block
//               count_out - samples accepted in the current block
// Revision    : 1.0 - initial release
// ============================================================================
module vedic_sum_accumulator #(
  parameter int ACC_W     = 40,
  parameter int BLOCK_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      sum_in,
  input  logic             cout_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic [CNT_W-1:0] count_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf_r;

  logic             accept;
  logic [ACC_W-1:0] sample;
  logic [ACC_W:0]   add_full;
  logic             carry;

  // The sample is unsigned and 33 bits wide. The cast zero-extends it to ACC_W bits.
  assign sample   = ACC_W'({cout_in, sum_in});
  assign add_full = {1'b0, acc} + {1'b0, sample};
  assign carry    = add_full[ACC_W];
  assign accept   = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Flush takes priority over any handshake.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state_nxt = (BLOCK_LEN == 1) ? ST_DONE : ST_ACCUM;
        ST_ACCUM: if (accept && count == LAST_CNT) state_nxt = ST_DONE;
        ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode. in_ready depends only on the state register and on the
  // reset level. It has no path from out_ready.
  always_comb begin
    in_ready  = rst_n && (state == ST_IDLE || state == ST_ACCUM);
    out_valid = (state == ST_DONE);
  end

  // Datapath: accumulator, sample counter and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      acc   <= '0;
      count <= '0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            // A single sample cannot overflow because ACC_W >= 33.
            acc   <= sample;
            count <= CNT_W'(1);
            ovf_r <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            count <= count + CNT_W'(1);
`ifdef SATURATE_EN
            // After a clamp, later samples are counted but not added.
            if (!ovf_r) begin
              if (carry) begin
                acc   <= '1;
                ovf_r <= 1'b1;
              end else begin
                acc <= add_full[ACC_W-1:0];
              end
            end
`else
            acc <= add_full[ACC_W-1:0];
            if (carry) ovf_r <= 1'b1;
`endif
          end
        end
        ST_DONE: begin
          // acc is kept so that acc_out still shows the last total after handoff.
          if (out_ready) count <= '0;
        end
        default: ;
      endcase
    end
  end

  assign acc_out   = acc;
  assign count_out = count;
  assign ovf       = ovf_r;

endmodule
`default_nettype wire

// File: tb/tb_vedic_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vedic_sum_accumulator
// Description : Directed self-checking bench for vedic_sum_accumulator.
//               It uses three instances:
//                 a: ACC_W=40, BLOCK_LEN=4
//                 b: ACC_W=34, BLOCK_LEN=4 (overflow case)
//                 c: ACC_W=40, BLOCK_LEN=1
//               Instances a and b share all their inputs. Instance c has its
//               own valid/ready signals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vedic_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sum_in;
  logic        cout_in;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic        c_in_valid;
  logic        c_out_ready;

  logic        a_in_ready, a_out_valid, a_ovf;
  logic [39:0] a_acc;
  logic [7:0]  a_cnt;
  logic        b_in_ready, b_out_valid, b_ovf;
  logic [33:0] b_acc;
  logic [7:0]  b_cnt;
  logic        c_in_ready, c_out_valid, c_ovf;
  logic [39:0] c_acc;
  logic [7:0]  c_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vedic_sum_accumulator #(.ACC_W(40), .BLOCK_LEN(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .cout_in(cout_in),
    .in_valid(in_valid), .in_ready(a_in_ready), .flush(flush),
    .acc_out(a_acc), .out_valid(a_out_valid), .out_ready(out_ready),
    .ovf(a_ovf), .count_out(a_cnt)
  );

  vedic_sum_accumulator #(.ACC_W(34), .BLOCK_LEN(4), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .cout_in(cout_in),
    .in_valid(in_valid), .in_ready(b_in_ready), .flush(flush),
    .acc_out(b_acc), .out_valid(b_out_valid), .out_ready(out_ready),
    .ovf(b_ovf), .count_out(b_cnt)
  );

  vedic_sum_accumulator #(.ACC_W(40), .BLOCK_LEN(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .cout_in(cout_in),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .flush(flush),
    .acc_out(c_acc), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .ovf(c_ovf), .count_out(c_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge. Outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one sample for one edge.
  task automatic send(input logic [31:0] s, input logic c);
    sum_in   = s;
    cout_in  = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Hand off the completed block with one out_ready cycle.
  task automatic release_block();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sum_in = 32'd5; cout_in = 1'b0; in_valid = 1'b1;
    flush = 1'b0; out_ready = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0;

    // ---- Reset: in_valid is high during reset, but nothing is accepted ----
    tick(); tick();
    check("rst_in_ready",  a_in_ready,  0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_acc",       a_acc,       0);
    check("rst_cnt",       a_cnt,       0);
    check("rst_ovf",       a_ovf,       0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("post_rst_in_ready", a_in_ready, 1);

    // ---- Basic block 1+2+3+4 ----
    send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b0);
    check("blk_cnt3",   a_cnt,       3);
    check("blk_ov0",    a_out_valid, 0);
    send(32'd4, 1'b0);
    check("blk_ov1",    a_out_valid, 1);
    check("blk_acc",    a_acc,       10);
    check("blk_cnt4",   a_cnt,       4);
    check("blk_ovf",    a_ovf,       0);
    check("blk_ready0", a_in_ready,  0);

    // ---- Backpressure: held in DONE, input ignored ----
    sum_in = 32'd99; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ov",    a_out_valid, 1);
      check("bp_acc",   a_acc,       10);
      check("bp_ready", a_in_ready,  0);
    end
    in_valid = 1'b0;
    release_block();
    check("rel_ov",    a_out_valid, 0);
    check("rel_cnt",   a_cnt,       0);
    check("rel_acc",   a_acc,       10);
    check("rel_ready", a_in_ready,  1);
    for (int i = 0; i < 4; i++) send(32'd5, 1'b0);
    check("blk5_acc", a_acc,       20);
    check("blk5_ov",  a_out_valid, 1);
    release_block();

    // ---- Flush drops the sample presented in the same cycle ----
    send(32'd7, 1'b0); send(32'd7, 1'b0);
    check("fl_pre_acc", a_acc, 14);
    flush = 1'b1;
    send(32'd7, 1'b0);
    flush = 1'b0;
    check("fl_cnt",   a_cnt,       0);
    check("fl_acc",   a_acc,       0);
    check("fl_ov",    a_out_valid, 0);
    check("fl_ready", a_in_ready,  1);
    for (int i = 0; i < 4; i++) send(32'd5, 1'b0);
    check("fl_blk_acc", a_acc, 20);
    check("fl_blk_ovf", a_ovf, 0);
    release_block();

    // ---- Maximum samples: instance a is wide enough, instance b overflows ----
    send(32'hFFFF_FFFF, 1'b1); send(32'hFFFF_FFFF, 1'b1);
    check("b_ovf_after2", b_ovf, 0);
    send(32'hFFFF_FFFF, 1'b1);
    check("b_ovf_after3", b_ovf, 1);
    send(32'hFFFF_FFFF, 1'b1);
    check("a_max_acc", a_acc, 64'h7_FFFF_FFFC);
    check("a_max_ovf", a_ovf, 0);
    check("b_ov",      b_out_valid, 1);
`ifdef SATURATE_EN
    check("b_acc_sat",  b_acc, 64'h3_FFFF_FFFF);
`else
    check("b_acc_wrap", b_acc, 64'h3_FFFF_FFFC);
`endif
    check("b_ovf_done", b_ovf, 1);
    release_block();
    check("b_ovf_held", b_ovf, 1);

    // The first accept of the next block clears the sticky ovf.
    send(32'd1, 1'b0);
    check("b_ovf_clr", b_ovf, 0);
    check("b_acc_new", b_acc, 1);

    // ---- Flush in DONE with out_ready=1 discards the result ----
    send(32'd1, 1'b0); send(32'd1, 1'b0); send(32'd1, 1'b0);
    check("fd_acc", a_acc,       4);
    check("fd_ov",  a_out_valid, 1);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("fd_ov_clr", a_out_valid, 0);
    check("fd_acc_clr", a_acc,      0);

    // ---- Reset mid-block loses the partial sum ----
    send(32'd9, 1'b0); send(32'd9, 1'b0);
    check("mr_cnt_pre", a_cnt, 2);
    rst_n = 1'b0;
    tick();
    check("mr_cnt", a_cnt, 0);
    check("mr_acc", a_acc, 0);
    rst_n = 1'b1;

    // ---- BLOCK_LEN=1: the block completes on its only accept ----
    sum_in = 32'd3; cout_in = 1'b1; c_in_valid = 1'b1;
    tick();
    c_in_valid = 1'b0;
    check("c_ov",    c_out_valid, 1);
    check("c_acc",   c_acc,       64'h1_0000_0003);
    check("c_cnt",   c_cnt,       1);
    check("c_ready", c_in_ready,  0);
    check("c_ovf",   c_ovf,       0);
    c_out_ready = 1'b1;
    tick();
    c_out_ready = 1'b0;
    check("c_rel_ov",  c_out_valid, 0);
    check("c_rel_cnt", c_cnt,       0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
